// File: rtl/rnn_input_feeder.sv
// rnn_input_feeder: host-written x-vector FIFO plus sequence launch FSM.
// Define RNN_FEEDER_CNT_EN to add the served_cnt pop counter output.
module rnn_input_feeder #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int START_LVL = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    input  logic [31:0]   wr_data,
    output logic          wr_ready,
    input  logic          start,
    input  logic          busy,
    input  logic          i_en,
    output logic          ready,
    output logic [31:0]   idata,
    output logic [AW:0]   level,
    output logic          underrun,
    output logic          overflow
`ifdef RNN_FEEDER_CNT_EN
    ,
    output logic [15:0]   served_cnt
`endif
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] START_L  = (AW+1)'(START_LVL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   idata_q, idata_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;
    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic          seen_q, seen_d;
    logic          wait_q, wait_d;
    logic          push, pop, full, empty, launch;
`ifdef RNN_FEEDER_CNT_EN
    logic [15:0]   cnt_q, cnt_d;
`endif

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign push     = wr_valid && !full;
    assign pop      = i_en && !empty;
    assign wr_ready = !full;
    assign ready    = ready_q;
    assign idata    = idata_q;
    assign level    = level_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        idata_d    = idata_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // An empty-FIFO request returns zero so the core never sees stale data.
        if (i_en) idata_d = pop ? mem_q[rd_ptr_q] : '0;
        if (i_en && empty)    underrun_d = 1'b1;
        if (wr_valid && full) overflow_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (start && !busy && level_q >= START_L) state_d = ARM;
            end
            ARM: begin
                state_d = RUN;
                seen_d  = busy;
                wait_d  = 1'b0;
            end
            RUN: begin
                // Without busy by the second RUN cycle the launch is lost.
                if (busy)        seen_d  = 1'b1;
                else if (seen_q) state_d = IDLE;
                else if (wait_q) state_d = IDLE;
                else             wait_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == ARM);
    end

    assign launch = (state_q == IDLE) && (state_d == ARM);

`ifdef RNN_FEEDER_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (launch)   cnt_d = '0;
        else if (pop) cnt_d = cnt_q + 16'd1;
    end

    assign served_cnt = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idata_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            seen_q     <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idata_q    <= idata_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            ready_q    <= ready_d;
            seen_q     <= seen_d;
            wait_q     <= wait_d;
        end
    end

    a_level_bound: assert property (
        @(posedge clk) disable iff (!reset_n) level_q <= FULL_LVL);

endmodule

// File: tb/tb_rnn_input_feeder.sv
// Bench for rnn_input_feeder: queue-based reference model checked every
// cycle on the falling edge, plus literal expectations for each scenario.
module tb_rnn_input_feeder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic        i_en = 1'b0;
    logic        ready;
    logic [31:0] idata;
    logic [4:0]  level;
    logic        underrun;
    logic        overflow;
`ifdef RNN_FEEDER_CNT_EN
    logic [15:0] served_cnt;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    rnn_input_feeder #(.DEPTH(16), .AW(4), .START_LVL(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .start    (start),
        .busy     (busy),
        .i_en     (i_en),
        .ready    (ready),
        .idata    (idata),
        .level    (level),
        .underrun (underrun),
        .overflow (overflow)
`ifdef RNN_FEEDER_CNT_EN
        ,
        .served_cnt (served_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, launch sequencing as a phase.
    logic [31:0] mq[$];
    logic [31:0] m_idata;
    bit          m_under, m_over;
    int          m_phase;   // 0 idle, 1 ready pulse, 2 waiting on core
    int          m_age;
    bit          m_seen;
    int          m_cnt;

    task automatic model_reset();
        mq.delete();
        m_idata = '0;
        m_under = 1'b0;
        m_over  = 1'b0;
        m_phase = 0;
        m_age   = 0;
        m_seen  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        int  sz;
        bit  popped;
        bit  go;
        sz = mq.size();
        popped = 1'b0;
        go = 1'b0;
        if (i_en) begin
            if (sz != 0) begin
                m_idata = mq.pop_front();
                popped = 1'b1;
            end else begin
                m_idata = '0;
                m_under = 1'b1;
            end
        end
        if (wr_valid) begin
            if (sz == 16) m_over = 1'b1;
            else          mq.push_back(wr_data);
        end
        if (m_phase == 0) begin
            if (start && !busy && sz >= 2) begin
                m_phase = 1;
                go = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_seen  = busy;
            m_age   = 0;
        end else begin
            m_age++;
            if (busy) m_seen = 1'b1;
            else if (m_seen || m_age >= 2) m_phase = 0;
        end
        if (go)          m_cnt = 0;
        else if (popped) m_cnt = (m_cnt + 1) % 65536;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (!reset_n) model_reset();
                chk("m_level", {27'b0, level}, 32'(mq.size()));
                chk("m_wr_ready", {31'b0, wr_ready}, {31'b0, mq.size() != 16});
                chk("m_ready", {31'b0, ready}, {31'b0, m_phase == 1});
                chk("m_idata", idata, m_idata);
                chk("m_underrun", {31'b0, underrun}, {31'b0, m_under});
                chk("m_overflow", {31'b0, overflow}, {31'b0, m_over});
`ifdef RNN_FEEDER_CNT_EN
                chk("m_served_cnt", {16'b0, served_cnt}, 32'(m_cnt));
`endif
                if (reset_n) model_step();
            end
        end
    end

    task automatic cyc(input logic wv, input logic [31:0] wd,
                       input logic ie, input logic st, input logic bz);
        wr_valid = wv;
        wr_data  = wd;
        i_en     = ie;
        start    = st;
        busy     = bz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_level", {27'b0, level}, 32'd0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_idata", idata, 32'd0);

        // T2 launch and served order
        cyc(1, 32'hA5A5_0001, 0, 0, 0);
        chk("t2_level1", {27'b0, level}, 32'd1);
        cyc(1, 32'h0000_0002, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t2_ready_hi", {31'b0, ready}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("t2_ready_lo", {31'b0, ready}, 32'd0);
        cyc(0, 0, 1, 0, 1);
        chk("t2_first", idata, 32'hA5A5_0001);
        cyc(0, 0, 1, 0, 1);
        chk("t2_second", idata, 32'h0000_0002);
        chk("t2_level0", {27'b0, level}, 32'd0);
`ifdef RNN_FEEDER_CNT_EN
        chk("t2_cnt", {16'b0, served_cnt}, 32'd2);
`endif
        cyc(0, 0, 0, 0, 0);

        // T3 fill past full
        for (int i = 0; i < 17; i++) begin
            cyc(1, 32'h3000_0000 + 32'(i), 0, 0, 0);
            if (i == 15) begin
                chk("t3_full_level", {27'b0, level}, 32'd16);
                chk("t3_no_ovf_yet", {31'b0, overflow}, 32'd0);
            end
        end
        chk("t3_level", {27'b0, level}, 32'd16);
        chk("t3_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("t3_overflow", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
        chk("t3_last_word", idata, 32'h3000_000F);
        chk("t3_drained", {27'b0, level}, 32'd0);

        // T4 underrun
        cyc(0, 0, 1, 0, 0);
        chk("t4_idata0", idata, 32'd0);
        chk("t4_underrun", {31'b0, underrun}, 32'd1);
        chk("t4_level0", {27'b0, level}, 32'd0);
        cyc(1, 32'hBEEF_0001, 0, 0, 0);
        chk("t4_sticky", {31'b0, underrun}, 32'd1);

        // T5 simultaneous push and pop at level 1
        cyc(1, 32'hBEEF_0002, 1, 0, 0);
        chk("t5_level", {27'b0, level}, 32'd1);
        chk("t5_old_head", idata, 32'hBEEF_0001);
        cyc(0, 0, 1, 0, 0);
        chk("t5_new_head", idata, 32'hBEEF_0002);

        // T6 streaming through the pointer wrap
        for (int i = 0; i < 40; i++)
            cyc(1, 32'h6000_0000 + 32'(i), (i > 0), 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t6_stream_last", idata, 32'h6000_0027);
        chk("t6_stream_empty", {27'b0, level}, 32'd0);

        // T6 lost launch then relaunch
        cyc(1, 32'h7000_0000, 0, 0, 0);
        cyc(1, 32'h7000_0001, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t6_ready1", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("t6_ready_gap", {31'b0, ready}, 32'd0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("t6_relaunch", {31'b0, ready}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        chk("t6_served", idata, 32'h7000_0000);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // T1 asynchronous reset mid-sequence with flags set
        for (int i = 0; i < 6; i++)
            cyc(1, 32'h1000_0000 + 32'(i), 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t1_pre_level", {27'b0, level}, 32'd5);
        cyc(0, 0, 0, 1, 0);
        chk("t1_pre_ready", {31'b0, ready}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("t1_level", {27'b0, level}, 32'd0);
        chk("t1_ready", {31'b0, ready}, 32'd0);
        chk("t1_idata", idata, 32'd0);
        chk("t1_underrun", {31'b0, underrun}, 32'd0);
        chk("t1_overflow", {31'b0, overflow}, 32'd0);
        chk("t1_wr_ready", {31'b0, wr_ready}, 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
